// File: rtl/vc_link_scheduler_if.sv
// Bundle between the per-VC buffers, the scheduler and the physical link.
// The slave view belongs to the scheduler. The master view belongs to
// whatever drives the VC side and credit returns.
interface vc_link_scheduler_if #(
  parameter int N_VC       = 3,
  parameter int FLIT_WIDTH = 34
);
  logic [N_VC-1:0]            vc_valid_i;
  logic [N_VC*FLIT_WIDTH-1:0] vc_fdata_i;
  logic [N_VC-1:0]            vc_ready_o;
  logic [N_VC-1:0]            credit_i;
  logic                       link_valid_o;
  logic [FLIT_WIDTH-1:0]      link_fdata_o;
  logic [1:0]                 link_vc_id_o;
  logic                       credit_err_o;
  logic                       proto_err_o;

  modport master (
    output vc_valid_i, vc_fdata_i, credit_i,
    input  vc_ready_o, link_valid_o, link_fdata_o, link_vc_id_o,
           credit_err_o, proto_err_o
  );

  modport slave (
    input  vc_valid_i, vc_fdata_i, credit_i,
    output vc_ready_o, link_valid_o, link_fdata_o, link_vc_id_o,
           credit_err_o, proto_err_o
  );
endinterface

// File: rtl/vc_link_scheduler.sv
// Per-output-port VC scheduler. Each cycle it makes a credit-gated
// round-robin pick among the VCs and pops that VC's buffer. The picked
// flit goes onto the link one cycle later through an output register.
// Per-VC head/tail framing is tracked, and protocol slips raise sticky flags.
module vc_link_scheduler #(
  parameter int N_VC       = 3,
  parameter int FLIT_WIDTH = 34,
  parameter int CREDITS    = 2
) (
  input  logic                clk,
  input  logic                arst,
  vc_link_scheduler_if.slave  bus
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam int IW = (N_VC > 1) ? $clog2(N_VC) : 1;

  typedef enum logic { IDLE = 1'b0, PKT = 1'b1 } pkt_state_e;
  typedef enum logic [1:0] {
    FT_HEAD   = 2'b00,
    FT_BODY_A = 2'b01,
    FT_BODY_B = 2'b10,
    FT_TAIL   = 2'b11
  } flit_type_e;

  logic [CW-1:0]         cnt [N_VC];
  pkt_state_e            pkt_state [N_VC];
  pkt_state_e            pkt_next  [N_VC];
  logic [1:0]            last_grant;
  logic [N_VC-1:0]       eligible;
  logic [N_VC-1:0]       full;
  logic [N_VC-1:0]       grant_oh;
  logic                  grant_valid;
  logic [1:0]            grant;
  logic [IW-1:0]         idx;
  logic [FLIT_WIDTH-1:0] sel_flit;
  flit_type_e            ftype;
  logic                  proto_bad;
  logic                  credit_over;

  // A VC may compete when it has a flit and a downstream slot.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    eligible = '0;
    full     = '0;
    for (int v = 0; v < N_VC; v++) begin
      eligible[v] = bus.vc_valid_i[v] && (cnt[v] != '0);
      full[v]     = (cnt[v] == CW'(CREDITS));
    end
    credit_over = |(bus.credit_i & ~grant_oh & full);
  end

  // Round-robin search from last_grant+1 upward. It scans from the far end,
  // so the nearest eligible VC is the one written last.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 2'd0;
    grant_oh    = '0;
    idx         = '0;
    for (int i = N_VC; i >= 1; i--) begin
      idx = IW'((int'(last_grant) + i) % N_VC);
      if (eligible[idx]) begin
        grant_valid   = 1'b1;
        grant         = 2'((int'(last_grant) + i) % N_VC);
        grant_oh      = '0;
        grant_oh[idx] = 1'b1;
      end
    end
  end

  // Select the granted VC's flit and decode its type.
  always_comb begin
    sel_flit = '0;
    for (int v = 0; v < N_VC; v++)
      if (grant_oh[v]) sel_flit = bus.vc_fdata_i[v*FLIT_WIDTH +: FLIT_WIDTH];
    ftype = flit_type_e'(sel_flit[FLIT_WIDTH-1 -: 2]);
  end

  // Packet FSM state register: one IDLE/PKT bit per VC.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (arst) begin
      for (int v = 0; v < N_VC; v++) pkt_state[v] <= IDLE;
    end else begin
      for (int v = 0; v < N_VC; v++) pkt_state[v] <= pkt_next[v];
    end
  end

  // Packet FSM next state: only the VC that transfers this cycle moves.
  always_comb begin
    proto_bad = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      pkt_next[v] = pkt_state[v];
      if (grant_oh[v]) begin
        unique case (pkt_state[v])
          IDLE: if (ftype == FT_HEAD) pkt_next[v] = PKT;
                else                  proto_bad   = 1'b1;
          PKT:  if (ftype == FT_HEAD)      proto_bad   = 1'b1;
                else if (ftype == FT_TAIL) pkt_next[v] = IDLE;
          default: pkt_next[v] = IDLE;
        endcase
      end
    end
  end

  // Pop strobe to the buffers: the one-hot grant, or nothing.
  always_comb begin
    bus.vc_ready_o = grant_oh;
  end

  // Credit counters: a send consumes a credit, a return restores one.
  // A return while the counter is full is dropped here and flagged below.
  always_ff @(posedge clk) begin
    // NOTE: the counter array is reset explicitly because eligibility depends on it.
    if (arst) begin
      for (int v = 0; v < N_VC; v++) cnt[v] <= CW'(CREDITS);
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        unique case ({grant_oh[v], bus.credit_i[v]})
          2'b10:   cnt[v] <= cnt[v] - CW'(1);
          2'b01:   if (!full[v]) cnt[v] <= cnt[v] + CW'(1);
          default: cnt[v] <= cnt[v];
        endcase
      end
    end
  end

  // Link output register and round-robin pointer.
  // The pointer advances only on a transfer.
  always_ff @(posedge clk) begin
    if (arst) begin
      bus.link_valid_o <= 1'b0;
      bus.link_fdata_o <= '0;
      bus.link_vc_id_o <= 2'd0;
      last_grant       <= 2'(N_VC - 1);
    end else if (grant_valid) begin
      bus.link_valid_o <= 1'b1;
      bus.link_fdata_o <= sel_flit;
      bus.link_vc_id_o <= grant;
      last_grant       <= grant;
    end else begin
      bus.link_valid_o <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (arst) begin
      bus.credit_err_o <= 1'b0;
      bus.proto_err_o  <= 1'b0;
    end else begin
      if (credit_over) bus.credit_err_o <= 1'b1;
      if (proto_bad)   bus.proto_err_o  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Bench for vc_link_scheduler. It pairs a behavioural model with directed
// scenarios and a randomized soak.
module tb_vc_link_scheduler;
  localparam int N_VC    = 3;
  localparam int FW      = 34;
  localparam int CREDITS = 2;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  vc_link_scheduler_if #(.N_VC(N_VC), .FLIT_WIDTH(FW)) bus();

  vc_link_scheduler #(.N_VC(N_VC), .FLIT_WIDTH(FW), .CREDITS(CREDITS)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  // Source side: one queue per VC stands in for a vc_buffer.
  logic [FW-1:0]   src [N_VC][$];
  logic [N_VC-1:0] vmask        = '1;
  logic [N_VC-1:0] extra_credit = '0;
  bit              auto_credit  = 1'b0;
  bit              rand_mode    = 1'b0;

  // Behavioural model state.
  int             m_cnt [N_VC];
  bit             m_pkt [N_VC];
  int             m_last;
  bit             m_lv;
  logic [FW-1:0]  m_ldata;
  int             m_lid;
  bit             m_cerr;
  bit             m_perr;
  int             mdl_pop = -1;

  task automatic model_reset();
    for (int v = 0; v < N_VC; v++) begin
      m_cnt[v] = CREDITS;
      m_pkt[v] = 1'b0;
    end
    m_last  = N_VC - 1;
    m_lv    = 1'b0;
    m_ldata = '0;
    m_lid   = 0;
    m_cerr  = 1'b0;
    m_perr  = 1'b0;
    mdl_pop = -1;
  endtask

  // Compare process. Mid-cycle it checks the outputs against the model.
  // It then advances the model to the state after the coming edge.
  initial begin : compare
    int g;
    int v;
    logic [FW-1:0] f;
    logic [1:0] t;
    logic [N_VC-1:0] exp_ready;
    model_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      g = -1;
      for (int k = 1; k <= N_VC; k++) begin
        v = (m_last + k) % N_VC;
        if (g < 0 && bus.vc_valid_i[v] && m_cnt[v] > 0) g = v;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("m_vc_ready", bus.vc_ready_o, exp_ready);
      check("m_link_valid", bus.link_valid_o, m_lv);
      check("m_link_vc_id", bus.link_vc_id_o, m_lid);
      check("m_link_fdata", bus.link_fdata_o, m_ldata);
      check("m_credit_err", bus.credit_err_o, m_cerr);
      check("m_proto_err", bus.proto_err_o, m_perr);
      if (arst) begin
        model_reset();
      end else begin
        mdl_pop = g;
        for (int w = 0; w < N_VC; w++) begin
          if (g == w && !bus.credit_i[w]) m_cnt[w]--;
          else if (g != w && bus.credit_i[w]) begin
            if (m_cnt[w] == CREDITS) m_cerr = 1'b1;
            else m_cnt[w]++;
          end
        end
        if (g >= 0) begin
          f       = bus.vc_fdata_i[g*FW +: FW];
          t       = f[FW-1 -: 2];
          m_lv    = 1'b1;
          m_ldata = f;
          m_lid   = g;
          m_last  = g;
          if (!m_pkt[g]) begin
            if (t == 2'b00) m_pkt[g] = 1'b1;
            else m_perr = 1'b1;
          end else begin
            if (t == 2'b00) m_perr = 1'b1;
            else if (t == 2'b11) m_pkt[g] = 1'b0;
          end
        end else begin
          m_lv = 1'b0;
        end
      end
    end
  end

  task automatic gen_packet(input int v);
    int nb;
    if ($urandom_range(0, 19) == 0) begin
      src[v].push_back(mk(2'($urandom_range(0, 3)), $urandom));
    end else begin
      src[v].push_back(mk(2'b00, $urandom));
      nb = $urandom_range(0, 2);
      for (int i = 0; i < nb; i++) src[v].push_back(mk(2'($urandom_range(1, 2)), $urandom));
      src[v].push_back(mk(2'b11, $urandom));
    end
  endtask

  task automatic apply(input bit rst, input logic [N_VC-1:0] cr);
    logic [N_VC*FW-1:0] fd;
    fd = '0;
    arst = rst;
    for (int v = 0; v < N_VC; v++) begin
      bus.vc_valid_i[v] = (src[v].size() > 0) && vmask[v];
      if (src[v].size() > 0) fd[v*FW +: FW] = src[v][0];
    end
    bus.vc_fdata_i = fd;
    bus.credit_i   = cr;
  endtask

  // Wait for one edge, retire what the model says was popped, and drive the
  // next cycle's inputs. Then settle so that outputs can be sampled.
  task automatic cycle(input bit rst);
    logic [N_VC-1:0] cr;
    bit r;
    @(posedge clk);
    #1;
    if (mdl_pop >= 0) begin
      if (src[mdl_pop].size() > 0) void'(src[mdl_pop].pop_front());
    end
    cr = extra_credit;
    if (auto_credit && mdl_pop >= 0) cr[mdl_pop] = 1'b1;
    r = rst;
    if (rand_mode) begin
      for (int v = 0; v < N_VC; v++) begin
        cr[v]    = ((m_cnt[v] < CREDITS) && ($urandom_range(0, 1) == 1)) ||
                   ($urandom_range(0, 99) == 0);
        vmask[v] = ($urandom_range(0, 3) != 0);
        if (src[v].size() == 0) gen_packet(v);
      end
      if ($urandom_range(0, 199) == 0) r = 1'b1;
    end
    apply(r, cr);
    #1;
  endtask

  task automatic do_reset();
    for (int v = 0; v < N_VC; v++) src[v].delete();
    extra_credit = '0;
    auto_credit  = 1'b0;
    vmask        = '1;
    cycle(1'b1);
    cycle(1'b1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin : driver
    // Reset with every VC valid, followed by the round-robin run.
    for (int v = 0; v < N_VC; v++) begin
      src[v].push_back(mk(2'b00, 32'h100 + v));
      src[v].push_back(mk(2'b01, 32'h200 + v));
      src[v].push_back(mk(2'b11, 32'h300 + v));
    end
    auto_credit = 1'b1;
    apply(1'b1, '0);
    cycle(1'b1);
    check("rst_vc_ready", bus.vc_ready_o, 3'b001);
    check("rst_link_valid", bus.link_valid_o, 1'b0);
    check("rst_link_fdata", bus.link_fdata_o, '0);
    check("rst_link_vc_id", bus.link_vc_id_o, 2'd0);
    check("rst_credit_err", bus.credit_err_o, 1'b0);
    check("rst_proto_err", bus.proto_err_o, 1'b0);
    cycle(1'b0);
    check("first_grant_vc0", bus.vc_ready_o, 3'b001);
    for (int k = 0; k < 9; k++) begin
      cycle(1'b0);
      check("rr_link_valid", bus.link_valid_o, 1'b1);
      check("rr_link_vc_id", bus.link_vc_id_o, k % 3);
      check("rr_link_fdata", bus.link_fdata_o,
            mk((k / 3 == 0) ? 2'b00 : (k / 3 == 1) ? 2'b01 : 2'b11, 32'h100 * (k / 3 + 1) + k % 3));
    end
    check("rr_drained_ready", bus.vc_ready_o, 3'b000);
    check("rr_proto_clean", bus.proto_err_o, 1'b0);
    cycle(1'b0);
    check("rr_idle_link", bus.link_valid_o, 1'b0);

    // Credit stall on VC1.
    do_reset();
    src[1].push_back(mk(2'b00, 32'hA0));
    src[1].push_back(mk(2'b01, 32'hA1));
    src[1].push_back(mk(2'b10, 32'hA2));
    src[1].push_back(mk(2'b11, 32'hA3));
    cycle(1'b0);
    check("stall_ready0", bus.vc_ready_o, 3'b010);
    cycle(1'b0);
    check("stall_send1_id", bus.link_vc_id_o, 2'd1);
    check("stall_ready1", bus.vc_ready_o, 3'b010);
    cycle(1'b0);
    check("stall_send2_valid", bus.link_valid_o, 1'b1);
    check("stall_ready_empty", bus.vc_ready_o, 3'b000);
    cycle(1'b0);
    check("stall_link_idle", bus.link_valid_o, 1'b0);
    cycle(1'b0);
    check("stall_still_idle", bus.link_valid_o, 1'b0);
    extra_credit = 3'b010;
    cycle(1'b0);
    check("stall_credit_cycle_ready", bus.vc_ready_o, 3'b000);
    extra_credit = '0;
    cycle(1'b0);
    check("stall_regrant", bus.vc_ready_o, 3'b010);
    cycle(1'b0);
    check("stall_resend_valid", bus.link_valid_o, 1'b1);
    check("stall_resend_fdata", bus.link_fdata_o, mk(2'b10, 32'hA2));
    check("stall_ready_again0", bus.vc_ready_o, 3'b000);
    check("stall_no_cerr", bus.credit_err_o, 1'b0);

    // Send and credit return on VC2 in the same cycle.
    do_reset();
    src[2].push_back(mk(2'b00, 32'hB0));
    src[2].push_back(mk(2'b01, 32'hB1));
    src[2].push_back(mk(2'b01, 32'hB2));
    src[2].push_back(mk(2'b11, 32'hB3));
    cycle(1'b0);
    check("simul_ready0", bus.vc_ready_o, 3'b100);
    extra_credit = 3'b100;
    cycle(1'b0);
    check("simul_head_id", bus.link_vc_id_o, 2'd2);
    check("simul_ready1", bus.vc_ready_o, 3'b100);
    extra_credit = '0;
    cycle(1'b0);
    check("simul_still_eligible", bus.vc_ready_o, 3'b100);
    check("simul_body_fdata", bus.link_fdata_o, mk(2'b01, 32'hB1));
    cycle(1'b0);
    check("simul_exhausted", bus.vc_ready_o, 3'b000);

    // Credit overflow, then a framing error.
    do_reset();
    extra_credit = 3'b001;
    cycle(1'b0);
    check("cerr_not_yet", bus.credit_err_o, 1'b0);
    extra_credit = '0;
    cycle(1'b0);
    check("cerr_set", bus.credit_err_o, 1'b1);
    repeat (3) cycle(1'b0);
    check("cerr_sticky", bus.credit_err_o, 1'b1);
    src[0].push_back(34'h1_0000_0005);
    cycle(1'b0);
    check("perr_ready", bus.vc_ready_o, 3'b001);
    check("perr_not_yet", bus.proto_err_o, 1'b0);
    cycle(1'b0);
    check("perr_flit_passes", bus.link_fdata_o, 34'h1_0000_0005);
    check("perr_link_valid", bus.link_valid_o, 1'b1);
    check("perr_set", bus.proto_err_o, 1'b1);
    do_reset();
    check("err_clear_cerr", bus.credit_err_o, 1'b0);
    check("err_clear_perr", bus.proto_err_o, 1'b0);

    // Reset arrives while a head flit sits in the output register.
    src[0].push_back(mk(2'b00, 32'hC0));
    cycle(1'b0);
    check("mid_ready", bus.vc_ready_o, 3'b001);
    cycle(1'b1);
    check("mid_head_on_link", bus.link_valid_o, 1'b1);
    src[0].push_back(mk(2'b11, 32'hC1));
    src[0].push_back(mk(2'b00, 32'hC2));
    cycle(1'b0);
    check("mid_link_dropped", bus.link_valid_o, 1'b0);
    check("mid_ready_after", bus.vc_ready_o, 3'b001);
    cycle(1'b0);
    check("mid_tail_first_perr", bus.proto_err_o, 1'b1);
    check("mid_tail_fdata", bus.link_fdata_o, mk(2'b11, 32'hC1));
    cycle(1'b0);
    check("mid_full_credit_2nd", bus.link_fdata_o, mk(2'b00, 32'hC2));
    check("mid_ready_end", bus.vc_ready_o, 3'b000);

    // Randomized soak against the model.
    do_reset();
    rand_mode = 1'b1;
    repeat (3000) cycle(1'b0);
    rand_mode = 1'b0;
    for (int v = 0; v < N_VC; v++) src[v].delete();
    repeat (3) cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
